// File: rtl/dec_scan_pkg.sv
// Shared types and helpers for the dec_scan registered one-hot decoder.
// Used by dec_scan (top) and dec_scan_dwell.
package dec_scan_pkg;

    // Widest select the onehot() helper supports; dec_scan casts down to its own OUT_W.
    localparam int MAX_SEL_W = 8;
    localparam int MAX_OUT_W = 1 << MAX_SEL_W;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DIRECT = 2'd1,
        SCAN   = 2'd2
    } state_e;

    function automatic logic [MAX_OUT_W-1:0] onehot(input logic [MAX_SEL_W-1:0] idx);
        logic [MAX_OUT_W-1:0] v;
        v      = '0;
        v[idx] = 1'b1;
        return v;
    endfunction

endpackage

// File: rtl/dec_scan_dwell.sv
// Dwell counter for SCAN mode: counts 0..HOLD-1 while ticked.
// tc_o flags the last cycle of a line's dwell.
module dec_scan_dwell #(
    parameter  int HOLD   = 1,
    localparam int HOLD_W = $clog2(HOLD + 1)
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr_i,
    input  logic tick_i,
    output logic tc_o
);

    logic [HOLD_W-1:0] cnt_q, cnt_d;

    assign tc_o = (cnt_q == HOLD_W'(HOLD - 1));

    // NOTE: always_comb assigns a default first so no path can infer a latch.
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (tick_i) begin
            cnt_d = tc_o ? '0 : cnt_q + 1'b1;
        end
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/dec_scan.sv
// Registered N-to-2^N one-hot decoder with DIRECT and SCAN modes.
// Define DEC_SCAN_ACTIVE_LOW_EN for one-cold (74x138-style) outputs.
module dec_scan
    import dec_scan_pkg::*;
#(
    parameter  int SEL_W = 3,
    parameter  int HOLD  = 1,
    localparam int OUT_W = 2 ** SEL_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             mode,
    input  logic [SEL_W-1:0] sel,
    input  logic             load,
    output logic [OUT_W-1:0] out,
    output logic [SEL_W-1:0] idx,
    output logic             valid,
    output logic             wrap
);

    if (SEL_W < 1 || SEL_W > MAX_SEL_W) begin : g_bad_sel_w
        $error("dec_scan: SEL_W out of range");
    end
    if (HOLD < 1 || HOLD > 65535) begin : g_bad_hold
        $error("dec_scan: HOLD out of range");
    end

`ifdef DEC_SCAN_ACTIVE_LOW_EN
    localparam logic [OUT_W-1:0] IDLE_OUT = '1;
`else
    localparam logic [OUT_W-1:0] IDLE_OUT = '0;
`endif

    state_e           state_q, state_d;
    logic [SEL_W-1:0] idx_q, idx_d;
    logic [OUT_W-1:0] out_q, out_d;
    logic             valid_q, wrap_q, wrap_d;
    logic             scan_run, dwell_tc;

    // Dwell only advances while staying in SCAN without a reload.
    assign scan_run = (state_q == SCAN) && (state_d == SCAN) && !load;

    dec_scan_dwell #(.HOLD(HOLD)) u_dwell (
        .clk    (clk),
        .rst_n  (rst_n),
        .clr_i  (!scan_run),
        .tick_i (scan_run),
        .tc_o   (dwell_tc)
    );

    always_comb begin
        state_d = IDLE;
        if (en) begin
            state_d = mode ? SCAN : DIRECT;
        end
    end

    always_comb begin
        idx_d  = idx_q;
        wrap_d = 1'b0;
        case (state_d)
            DIRECT: idx_d = sel;
            SCAN: begin
                if (state_q == IDLE || (state_q == SCAN && load)) begin
                    idx_d = sel;
                end else if (scan_run && dwell_tc) begin
                    idx_d  = idx_q + 1'b1;
                    wrap_d = (idx_q == SEL_W'(OUT_W - 1));
                end
            end
            default: idx_d = idx_q;
        endcase
    end

    always_comb begin
        out_d = IDLE_OUT;
        if (state_d != IDLE) begin
`ifdef DEC_SCAN_ACTIVE_LOW_EN
            out_d = ~OUT_W'(onehot(MAX_SEL_W'(idx_d)));
`else
            out_d = OUT_W'(onehot(MAX_SEL_W'(idx_d)));
`endif
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            idx_q   <= '0;
            out_q   <= IDLE_OUT;
            valid_q <= 1'b0;
            wrap_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            out_q   <= out_d;
            valid_q <= (state_d != IDLE);
            wrap_q  <= wrap_d;
        end
    end

    assign out   = out_q;
    assign idx   = idx_q;
    assign valid = valid_q;
    assign wrap  = wrap_q;

endmodule
